// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, 8N1 frame shape, divider helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 8N1 framing
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  // Clocks per bit, truncated; shared with the receiver so both ends agree.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/level and a dropped-write pulse.
// Latency: a pushed byte is visible at the head one clock after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   level_d;

  // A pop frees a slot on the same edge, so a full FIFO can still take a write.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Next occupancy; full/empty are derived from it so all three flags stay coherent.
  always_comb begin
    level_d = level;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level + (AW + 1)'(1);
      2'b01:   level_d = level - (AW + 1)'(1);
      default: level_d = level;
    endcase
  end

  // Pointers, occupancy flags and the overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_d;
      full     <= (level_d == DEPTH_L);
      empty    <= (level_d == '0);
      overflow <= push && full && !pop_ok;
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and go out LSB first on txd.
// Latency: write into an empty idle block -> start bit driven one clock after the write edge.
// Backpressure: none upstream; writes while full are dropped and flagged by overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               overflow,
  output logic               txd
);

  localparam int              DIV      = calc_div(CLK_HZ, BAUD);
  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic             txd_q, txd_d;
  logic             pop;
  logic             bit_end;
  logic [7:0]       head;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  assign bit_end = (baud_q == CNT_LAST);
  assign busy    = (state_q != IDLE);
  assign txd     = txd_q;

  // Frame sequencer: the popped byte lives in shift_q, so later writes cannot disturb it.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = '0;
    txd_d     = txd_q;
    pop       = 1'b0;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset forces the line high and abandons any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
    end
  end

endmodule
